// File: rtl/multi_channel_mem_if.sv
// Bus bundle for multi_channel_mem: write, read, flush and status signals.
interface multi_channel_mem_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = $clog2(NUM_CH)
);
    logic                  wr_en;
    logic [CH_W-1:0]       wr_ch;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  rd_en;
    logic [CH_W-1:0]       rd_ch;
    logic                  rd_keep;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [CH_W-1:0]       rd_ch_out;
    logic                  clr_en;
    logic [CH_W-1:0]       clr_ch;
    logic [NUM_CH-1:0]     full;
    logic [NUM_CH-1:0]     empty;
    logic                  ovf_err;
    logic                  udf_err;
    logic                  rd_perr;

    modport master (
        output wr_en, wr_ch, wr_data, rd_en, rd_ch, rd_keep, clr_en, clr_ch,
        input  wr_ready, rd_valid, rd_data, rd_ch_out, full, empty, ovf_err, udf_err, rd_perr
    );
    modport slave (
        input  wr_en, wr_ch, wr_data, rd_en, rd_ch, rd_keep, clr_en, clr_ch,
        output wr_ready, rd_valid, rd_data, rd_ch_out, full, empty, ovf_err, udf_err, rd_perr
    );
endinterface

// File: rtl/multi_channel_mem.sv
// NUM_CH independent FIFOs sharing one simple-dual-port RAM, with peek reads and flush.
// Define MULTI_CHANNEL_MEM_PARITY_EN to store/check an even parity bit per word.
module multi_channel_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input logic clk,
    input logic rst,
    multi_channel_mem_if.slave bus
);
`ifdef MULTI_CHANNEL_MEM_PARITY_EN
    localparam int WORD_W = DATA_WIDTH + 1;
`else
    localparam int WORD_W = DATA_WIDTH;
`endif
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [WORD_W-1:0] mem [NUM_CH*DEPTH];
    logic [WORD_W-1:0] ram_q;
    logic [WORD_W-1:0] wr_word;

    logic [NUM_CH-1:0][ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [NUM_CH-1:0][ADDR_W:0]   count;
    logic [NUM_CH-1:0]             full_v, empty_v, push, pop, clr_hit;

    logic wr_clr, rd_clr, wr_acc, rd_acc, wr_rej, rd_rej;
    logic rd_valid, ovf_err, udf_err;
    logic [CH_W-1:0] rd_ch_out;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            full_v[c]  = (count[c] == FULL_CNT);
            empty_v[c] = (count[c] == '0);
        end
    end

    // Flags are those at the start of the cycle: no write->read bypass.
    assign wr_clr = bus.clr_en && (bus.clr_ch == bus.wr_ch);
    assign rd_clr = bus.clr_en && (bus.clr_ch == bus.rd_ch);
    assign wr_acc = bus.wr_en && !full_v[bus.wr_ch] && !wr_clr;
    assign wr_rej = bus.wr_en &&  full_v[bus.wr_ch] && !wr_clr;
    assign rd_acc = bus.rd_en && !empty_v[bus.rd_ch] && !rd_clr;
    assign rd_rej = bus.rd_en &&  empty_v[bus.rd_ch] && !rd_clr;

    always_comb begin
        push    = '0;
        pop     = '0;
        clr_hit = '0;
        if (bus.clr_en)              clr_hit[bus.clr_ch] = 1'b1;
        if (wr_acc)                  push[bus.wr_ch]     = 1'b1;
        if (rd_acc && !bus.rd_keep)  pop[bus.rd_ch]      = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst || clr_hit[c]) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end else begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
                if (push[c] != pop[c])
                    count[c] <= push[c] ? count[c] + 1'b1 : count[c] - 1'b1;
            end
        end
    end

`ifdef MULTI_CHANNEL_MEM_PARITY_EN
    assign wr_word = {^bus.wr_data, bus.wr_data};
`else
    assign wr_word = bus.wr_data;
`endif

    always_ff @(posedge clk) begin
        if (wr_acc) mem[{bus.wr_ch, wr_ptr[bus.wr_ch]}] <= wr_word;
    end

    // RAM output register; only meaningful while rd_valid is set.
    always_ff @(posedge clk) begin
        if (rd_acc) ram_q <= mem[{bus.rd_ch, rd_ptr[bus.rd_ch]}];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            rd_ch_out <= '0;
            ovf_err   <= 1'b0;
            udf_err   <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) rd_ch_out <= bus.rd_ch;
            ovf_err  <= ovf_err | wr_rej;
            udf_err  <= udf_err | rd_rej;
        end
    end

    assign bus.wr_ready  = !full_v[bus.wr_ch];
    assign bus.rd_valid  = rd_valid;
    assign bus.rd_data   = rd_valid ? ram_q[DATA_WIDTH-1:0] : '0;
    assign bus.rd_ch_out = rd_ch_out;
    assign bus.full      = full_v;
    assign bus.empty     = empty_v;
    assign bus.ovf_err   = ovf_err;
    assign bus.udf_err   = udf_err;
`ifdef MULTI_CHANNEL_MEM_PARITY_EN
    assign bus.rd_perr   = rd_valid && (^ram_q);
`else
    assign bus.rd_perr   = 1'b0;
`endif
endmodule

// File: tb/tb_multi_channel_mem.sv
// Scoreboard bench for multi_channel_mem: queue model per channel, expected reads queued at issue.
module tb_multi_channel_mem;
    localparam int DW  = 16;
    localparam int NCH = 4;
    localparam int DEP = 256;
    localparam int CHW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_channel_mem_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();
    multi_channel_mem #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { int ch; int data; bit perr; } exp_t;

    int   mdl [NCH][$];
    exp_t exp_q [$];
    bit   exp_ovf, exp_udf, perr_next;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input longint got, input longint want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic idle_inputs();
        bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_data = '0;
        bus.rd_en = 1'b0; bus.rd_ch = '0; bus.rd_keep = 1'b0;
        bus.clr_en = 1'b0; bus.clr_ch = '0;
    endtask

    task automatic chk_flags(input string tag);
        logic [NCH-1:0] ef, ee;
        for (int c = 0; c < NCH; c++) begin
            ef[c] = (mdl[c].size() == DEP);
            ee[c] = (mdl[c].size() == 0);
        end
        chk({tag, ".full"},  bus.full,  ef);
        chk({tag, ".empty"}, bus.empty, ee);
        chk({tag, ".ovf"},   bus.ovf_err, exp_ovf);
        chk({tag, ".udf"},   bus.udf_err, exp_udf);
    endtask

    // One clock: drive, update model, then check the cycle-after outputs.
    task automatic step(input bit we, input int wch, input int wd, input bit re, input int rch,
                        input bit keep, input bit ce = 0, input int cch = 0);
        bit   w_ok, r_ok;
        exp_t e;
        bus.wr_en = we; bus.wr_ch = wch[CHW-1:0]; bus.wr_data = wd[DW-1:0];
        bus.rd_en = re; bus.rd_ch = rch[CHW-1:0]; bus.rd_keep = keep;
        bus.clr_en = ce; bus.clr_ch = cch[CHW-1:0];
        #1;
        chk("wr_ready", bus.wr_ready, mdl[wch].size() != DEP);
        r_ok = 0;
        w_ok = 0;
        if (re && !(ce && cch == rch)) begin
            if (mdl[rch].size() == 0) exp_udf = 1;
            else begin
                r_ok = 1;
                e.ch = rch; e.data = mdl[rch][0]; e.perr = perr_next;
                exp_q.push_back(e);
            end
        end
        if (we && !(ce && cch == wch)) begin
            if (mdl[wch].size() == DEP) exp_ovf = 1;
            else w_ok = 1;
        end
        if (r_ok && !keep) void'(mdl[rch].pop_front());
        if (w_ok) mdl[wch].push_back(wd);
        if (ce) mdl[cch].delete();
        @(posedge clk); #1;
        idle_inputs();
        chk("rd_valid", bus.rd_valid, r_ok);
        if (bus.rd_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_data",   bus.rd_data,   e.data);
            chk("rd_ch_out", bus.rd_ch_out, e.ch);
            chk("rd_perr",   bus.rd_perr,   e.perr);
        end else begin
            chk("rd_data_idle", bus.rd_data, 0);
            if (!bus.rd_valid && exp_q.size() > 0) void'(exp_q.pop_front());
        end
        chk_flags("step");
    endtask

    task automatic do_reset(input bit with_rd);
        idle_inputs();
        bus.rd_en = with_rd;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rd_en = 1'b0;
        for (int c = 0; c < NCH; c++) mdl[c].delete();
        exp_q.delete();
        exp_ovf = 0; exp_udf = 0; perr_next = 0;
        chk("rst.rd_valid",  bus.rd_valid, 0);
        chk("rst.rd_data",   bus.rd_data, 0);
        chk("rst.rd_ch_out", bus.rd_ch_out, 0);
        chk("rst.rd_perr",   bus.rd_perr, 0);
        chk("rst.empty",     bus.empty, 4'hF);
        chk("rst.full",      bus.full, 4'h0);
        chk("rst.ovf",       bus.ovf_err, 0);
        chk("rst.udf",       bus.udf_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        do_reset(0);

        // Fill ch0, overflow, full+pop same cycle, drain
        for (int i = 0; i < DEP; i++) step(1, 0, i, 0, 0, 0);
        chk("t1.full0", bus.full[0], 1);
        step(1, 0, 16'h7777, 0, 0, 0);
        chk("t1.ovf", bus.ovf_err, 1);
        step(1, 0, 16'h5555, 1, 0, 0);
        for (int i = 1; i < DEP; i++) step(0, 0, 0, 1, 0, 0);
        chk("t1.empty0", bus.empty[0], 1);

        // Interleaved channels, round-robin reads
        do_reset(0);
        for (int i = 0; i < 10; i++)
            for (int c = 0; c < NCH; c++) step(1, c, c*100 + i, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            for (int c = 0; c < NCH; c++) step(0, 0, 0, 1, c, 0);

        // Peek then pop
        do_reset(0);
        step(1, 2, 16'hAAAA, 0, 0, 0);
        step(1, 2, 16'hBBBB, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 2, 1);
        chk("t3.count2", mdl[2].size() == 2 && bus.empty[2] == 1'b0, 1);
        step(0, 0, 0, 1, 2, 0);
        step(0, 0, 0, 1, 2, 0);
        chk("t3.empty2", bus.empty[2], 1);

        // Steady push+pop on ch1 long enough to wrap pointers
        do_reset(0);
        for (int i = 0; i < 5; i++) step(1, 1, i + 1, 0, 0, 0);
        for (int i = 0; i < 260; i++) step(1, 1, 1000 + i, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, 0);

        // Underflow, write+read on empty channel, flush with in-flight read
        do_reset(0);
        step(0, 0, 0, 1, 3, 0);
        chk("t5.udf", bus.udf_err, 1);
        step(1, 2, 16'h0007, 1, 2, 0);
        step(0, 0, 0, 1, 2, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 16'h0100 + i, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(1, 1, 16'h0999, 1, 1, 0, 1, 1);
        chk("t5.empty1", bus.empty[1], 1);
        chk("t5.no_ovf", bus.ovf_err, 0);
        step(1, 1, 16'h0abc, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);

        // Reset mid-drain
        do_reset(0);
        for (int i = 0; i < 4; i++) step(1, 0, 16'h0f00 + i, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 1, 16'h0001, 1, 0, 0);
        do_reset(1);
`ifdef MULTI_CHANNEL_MEM_PARITY_EN
        step(1, 0, 16'h1234, 0, 0, 0);
        dut.mem[0][DW] = ~dut.mem[0][DW];
        perr_next = 1;
        step(0, 0, 0, 1, 0, 0);
        perr_next = 0;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
